// File: rtl/instruction_fetch_pkg.sv
// Shared widths, the NOP encoding and the PC/instruction types used by the fetch stage.
package instruction_fetch_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int MEM_DEPTH  = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] pc_t;
    typedef logic [DATA_WIDTH-1:0] instr_t;

    localparam instr_t NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/instruction_memory.sv
// 256x32 instruction store: one synchronous host write port, one combinational read port.
module instruction_memory
    import instruction_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   we,
    input  pc_t    waddr,
    input  instr_t wdata,
    input  pc_t    raddr,
    output instr_t rdata
);

    // Contents start at zero and are deliberately untouched by reset.
    instr_t mem_q [MEM_DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, sequential/branch next-PC selection and the IF/ID output registers.
// Define IF_BRANCH_FLUSH_EN to replace the instruction fetched on a taken-branch edge with a NOP.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        i_PCWrite,
    input  logic        i_PCSrc,
    input  logic [7:0]  i_PCBranch,
    input  logic        i_write_inst_mem,
    input  logic [7:0]  i_inst_mem_addr,
    input  logic [31:0] i_inst_mem_data,
    output logic [7:0]  o_PCNext,
    output logic [31:0] o_instruction
);

    pc_t    pc_q;
    pc_t    pc_d;
    pc_t    pc_plus1;
    pc_t    pc_next_q;
    instr_t instr_q;
    instr_t instr_d;
    instr_t mem_rdata;
    logic   fetch_en;

    instruction_memory u_imem (
        .clk   (clk),
        .we    (i_write_inst_mem),
        .waddr (i_inst_mem_addr),
        .wdata (i_inst_mem_data),
        .raddr (pc_q),
        .rdata (mem_rdata)
    );

    assign fetch_en = enable & i_PCWrite;
    assign pc_plus1 = pc_q + pc_t'(1);

    always_comb begin
        pc_d    = i_PCSrc ? i_PCBranch : pc_plus1;
`ifdef IF_BRANCH_FLUSH_EN
        instr_d = i_PCSrc ? NOP_INSTR : mem_rdata;
`else
        instr_d = mem_rdata;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= '0;
            pc_next_q <= '0;
            instr_q   <= NOP_INSTR;
        end else if (fetch_en) begin
            pc_q      <= pc_d;
            pc_next_q <= pc_plus1;
            instr_q   <= instr_d;
        end
    end

    assign o_PCNext      = pc_next_q;
    assign o_instruction = instr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic vs. a reference model.
module tb_instruction_fetch;

`ifdef IF_BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        i_PCWrite = 1'b0;
    logic        i_PCSrc = 1'b0;
    logic [7:0]  i_PCBranch = '0;
    logic        i_write_inst_mem = 1'b0;
    logic [7:0]  i_inst_mem_addr = '0;
    logic [31:0] i_inst_mem_data = '0;
    logic [7:0]  o_PCNext;
    logic [31:0] o_instruction;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural state only.
    logic [31:0] mem_m [256];
    int          exp_pc = 0;
    int          exp_next = 0;
    logic [31:0] exp_instr = '0;

    instruction_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .i_PCWrite        (i_PCWrite),
        .i_PCSrc          (i_PCSrc),
        .i_PCBranch       (i_PCBranch),
        .i_write_inst_mem (i_write_inst_mem),
        .i_inst_mem_addr  (i_inst_mem_addr),
        .i_inst_mem_data  (i_inst_mem_data),
        .o_PCNext         (o_PCNext),
        .o_instruction    (o_instruction)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_pc = 0;
            exp_next = 0;
            exp_instr = '0;
        end else begin
            if (enable && i_PCWrite) begin
                exp_instr = (FLUSH && i_PCSrc) ? 32'h0 : mem_m[exp_pc];
                exp_next  = (exp_pc + 1) % 256;
                exp_pc    = i_PCSrc ? int'(i_PCBranch) : (exp_pc + 1) % 256;
            end
            if (i_write_inst_mem) mem_m[i_inst_mem_addr] = i_inst_mem_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({o_instruction, o_PCNext} !== 40'h0) begin
            n_err++;
            $display("FAIL reset_state: got instr=%h next=%0d, want instr=0 next=0", o_instruction, o_PCNext);
        end
        $display("reset_state instr=%h next=%0d", o_instruction, o_PCNext);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_write_inst_mem = 1'b1;
            i_inst_mem_addr  = 8'(i);
            i_inst_mem_data  = 32'((i + 1) * 10);
            cyc();
            n_cmp++;
            if ({o_instruction, o_PCNext} !== 40'h0) begin
                n_err++;
                $display("FAIL load_disabled[%0d]: got instr=%0d next=%0d, want 0/0", i, o_instruction, o_PCNext);
            end
            $display("load addr=%0d data=%0d instr=%0d next=%0d", i, (i + 1) * 10, o_instruction, o_PCNext);
        end
        i_write_inst_mem = 1'b0;
    endtask

    task automatic test_sequential();
        enable = 1'b1;
        i_PCWrite = 1'b1;
        i_PCSrc = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            n_cmp++;
            if (o_instruction !== 32'(10 * k) || o_PCNext !== 8'(k)) begin
                n_err++;
                $display("FAIL seq_fetch[%0d]: got (%0d,%0d), want (%0d,%0d)", k, o_instruction, o_PCNext, 10 * k, k);
            end
            $display("seq fetch instr=%0d next=%0d", o_instruction, o_PCNext);
        end
    endtask

    task automatic test_branch();
        logic [31:0] want_i [3];
        logic [7:0]  want_n [3];
        want_i[0] = FLUSH ? 32'd0 : 32'd60;  want_n[0] = 8'd6;
        want_i[1] = 32'd20;                  want_n[1] = 8'd2;
        want_i[2] = 32'd30;                  want_n[2] = 8'd3;
        for (int k = 0; k < 3; k++) begin
            i_PCSrc = (k == 0);
            i_PCBranch = 8'd1;
            cyc();
            n_cmp++;
            if (o_instruction !== want_i[k] || o_PCNext !== want_n[k]) begin
                n_err++;
                $display("FAIL branch[%0d]: got (%0d,%0d), want (%0d,%0d)", k, o_instruction, o_PCNext, want_i[k], want_n[k]);
            end
            $display("branch step%0d instr=%0d next=%0d", k, o_instruction, o_PCNext);
        end
        i_PCSrc = 1'b0;
    endtask

    task automatic test_stall();
        i_PCWrite = 1'b0;
        i_PCSrc = 1'b1;
        i_PCBranch = 8'd200;
        cyc();
        n_cmp++;
        if (o_instruction !== 32'd30 || o_PCNext !== 8'd3) begin
            n_err++;
            $display("FAIL stall_hold: got (%0d,%0d), want (30,3)", o_instruction, o_PCNext);
        end
        $display("stall instr=%0d next=%0d", o_instruction, o_PCNext);
        i_PCWrite = 1'b1;
        i_PCSrc = 1'b0;
        cyc();
        n_cmp++;
        if (o_instruction !== 32'd40 || o_PCNext !== 8'd4) begin
            n_err++;
            $display("FAIL stall_resume: got (%0d,%0d), want (40,4)", o_instruction, o_PCNext);
        end
        $display("resume instr=%0d next=%0d", o_instruction, o_PCNext);
    endtask

    task automatic test_wrap();
        logic [31:0] want_i [3];
        logic [7:0]  want_n [3];
        want_i[0] = FLUSH ? 32'd0 : 32'd50;  want_n[0] = 8'd5;
        want_i[1] = 32'd0;                   want_n[1] = 8'd0;
        want_i[2] = 32'd10;                  want_n[2] = 8'd1;
        for (int k = 0; k < 3; k++) begin
            i_PCSrc = (k == 0);
            i_PCBranch = 8'd255;
            cyc();
            n_cmp++;
            if (o_instruction !== want_i[k] || o_PCNext !== want_n[k]) begin
                n_err++;
                $display("FAIL wrap[%0d]: got (%0d,%0d), want (%0d,%0d)", k, o_instruction, o_PCNext, want_i[k], want_n[k]);
            end
            $display("wrap step%0d instr=%0d next=%0d", k, o_instruction, o_PCNext);
        end
        i_PCSrc = 1'b0;
    endtask

    task automatic test_reset_midrun();
        cyc();
        n_cmp++;
        if (o_instruction !== 32'd20 || o_PCNext !== 8'd2) begin
            n_err++;
            $display("FAIL pre_reset: got (%0d,%0d), want (20,2)", o_instruction, o_PCNext);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({o_instruction, o_PCNext} !== 40'h0) begin
            n_err++;
            $display("FAIL async_reset: got (%0d,%0d), want (0,0)", o_instruction, o_PCNext);
        end
        $display("async reset instr=%0d next=%0d", o_instruction, o_PCNext);
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_instruction !== 32'd10 || o_PCNext !== 8'd1) begin
            n_err++;
            $display("FAIL post_reset: got (%0d,%0d), want (10,1)", o_instruction, o_PCNext);
        end
        $display("post reset instr=%0d next=%0d", o_instruction, o_PCNext);
    endtask

    task automatic test_read_before_write();
        logic [31:0] want_i [3];
        logic [7:0]  want_n [3];
        want_i[0] = 32'd20;                  want_n[0] = 8'd2;
        want_i[1] = FLUSH ? 32'd0 : 32'd30;  want_n[1] = 8'd3;
        want_i[2] = 32'hDEAD_BEEF;           want_n[2] = 8'd2;
        for (int k = 0; k < 3; k++) begin
            i_write_inst_mem = (k == 0);
            i_inst_mem_addr  = 8'd1;
            i_inst_mem_data  = 32'hDEAD_BEEF;
            i_PCSrc = (k == 1);
            i_PCBranch = 8'd1;
            cyc();
            n_cmp++;
            if (o_instruction !== want_i[k] || o_PCNext !== want_n[k]) begin
                n_err++;
                $display("FAIL rbw[%0d]: got (%h,%0d), want (%h,%0d)", k, o_instruction, o_PCNext, want_i[k], want_n[k]);
            end
            $display("rbw step%0d instr=%h next=%0d", k, o_instruction, o_PCNext);
        end
        i_write_inst_mem = 1'b0;
        i_PCSrc = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            enable           = ($urandom_range(0, 9) != 0);
            i_PCWrite        = ($urandom_range(0, 5) != 0);
            i_PCSrc          = ($urandom_range(0, 6) == 0);
            i_PCBranch       = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
            i_write_inst_mem = ($urandom_range(0, 2) == 0);
            i_inst_mem_addr  = 8'($urandom_range(0, 15));
            i_inst_mem_data  = $urandom;
            cyc();
            n_cmp++;
            if (o_instruction !== exp_instr || o_PCNext !== 8'(exp_next)) begin
                n_err++;
                $display("FAIL random[%0d]: got (%h,%0d), want (%h,%0d)", n, o_instruction, o_PCNext, exp_instr, exp_next);
            end
            $display("rand %0d en=%0b pw=%0b src=%0b br=%0d we=%0b instr=%h next=%0d",
                     n, enable, i_PCWrite, i_PCSrc, i_PCBranch, i_write_inst_mem, o_instruction, o_PCNext);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem_m[a] = '0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_wrap();
        test_reset_midrun();
        test_read_before_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
